accreg_bank: RTL and testbench

Parametrised accumulator register bank for the HWPE convolution datapath. It sits between the multiplier array and the ReLU/memory-write stage. It accumulates NPE signed products per cycle into one of NBANK banks with saturation, and serves single-element config read/write. It drains a bank LANES elements per beat over a valid/ready stream, with optional ReLU and clear-on-drain. It generalises the fixed 8x16x32, 4-lane accumulator with a backpressured drain, overwrite-on-first-MAC, and bank-conflict detection.

---
 rtl/accreg_bank.sv | 200 ++++++++++++++++++++
 tb/tb_accreg_bank.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accreg_bank.sv
// accreg_bank
// ------------
// Accumulator register bank for the convolution datapath. Each cycle it can
// add a vector of NPE signed products into one of NBANK banks, using
// saturating arithmetic. It also serves single-element config reads and
// writes. A bank can be drained LANES elements per beat over a valid/ready
// stream, with optional ReLU. Every element is cleared as soon as its beat
// transfers.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   mac_valid/bank/clr/prod       product vector in; clr overwrites instead of adding
//   cfg_wen/wbank/wpe/wdata       single-element write
//   cfg_ren/rclr/rbank/rpe        single-element read, optional clear-on-read
//   cfg_rvalid/rdata              registered read response (rdata holds until next read)
//   drain_start/bank/relu         start a drain of one bank
//   drain_busy, drain_done        drain in progress / one-cycle completion pulse
//   out_valid/ready/data/last     drain stream, lane j = element beat*LANES+j
//   mac_conflict                  sticky: a MAC to the bank being drained was dropped
module accreg_bank #(
    parameter int NBANK  = 8,
    parameter int NPE    = 16,
    parameter int ACC_W  = 32,
    parameter int PROD_W = 20,
    parameter int LANES  = 4,
    localparam int BW    = $clog2(NBANK),
    localparam int PW    = $clog2(NPE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mac_valid,
    input  logic [BW-1:0]           mac_bank,
    input  logic                    mac_clr,
    input  logic [NPE*PROD_W-1:0]   mac_prod,
    input  logic                    cfg_wen,
    input  logic [BW-1:0]           cfg_wbank,
    input  logic [PW-1:0]           cfg_wpe,
    input  logic [ACC_W-1:0]        cfg_wdata,
    input  logic                    cfg_ren,
    input  logic                    cfg_rclr,
    input  logic [BW-1:0]           cfg_rbank,
    input  logic [PW-1:0]           cfg_rpe,
    output logic                    cfg_rvalid,
    output logic [ACC_W-1:0]        cfg_rdata,
    input  logic                    drain_start,
    input  logic [BW-1:0]           drain_bank,
    input  logic                    drain_relu,
    output logic                    drain_busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*ACC_W-1:0]  out_data,
    output logic                    out_last,
    output logic                    drain_done,
    output logic                    mac_conflict
);

    localparam int NBEAT = NPE / LANES;
    localparam int BTW   = (NBEAT > 1) ? $clog2(NBEAT) : 1;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t           state, state_n;
    logic [BTW-1:0]   beat, beat_n;
    logic [BW-1:0]    dbank, dbank_n;
    logic             relu, relu_n;
    logic             done_n;

    logic [ACC_W-1:0] acc [NBANK][NPE];

    logic mac_accept;
    logic cfg_wok;
    logic rd_clr;
    logic xfer;

    // Saturating add. The sum is formed one bit wider than the accumulator,
    // so the top two bits show overflow in either direction.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [PROD_W-1:0] p);
        logic [ACC_W:0] sum;
        sum = {a[ACC_W-1], a} + {{(ACC_W+1-PROD_W){p[PROD_W-1]}}, p};
        case (sum[ACC_W:ACC_W-1])
            2'b01:   sat_add = {1'b0, {(ACC_W-1){1'b1}}};
            2'b10:   sat_add = {1'b1, {(ACC_W-1){1'b0}}};
            default: sat_add = sum[ACC_W-1:0];
        endcase
    endfunction

    assign drain_busy = (state == DRAIN);
    assign out_valid  = (state == DRAIN);
    assign out_last   = out_valid && (beat == BTW'(NBEAT - 1));
    assign xfer       = out_valid && out_ready;

    // MACs into the bank being drained are dropped. This keeps out_data
    // steady while the stream is stalled.
    assign mac_accept = mac_valid && !(drain_busy && (mac_bank == dbank));
    // A config write loses to an accepted MAC on the same bank.
    assign cfg_wok    = cfg_wen && !(mac_accept && (mac_bank == cfg_wbank));
    assign rd_clr     = cfg_ren && cfg_rclr;

    // Drain FSM next-state logic. A start request is only honoured when idle.
    always_comb begin
        state_n = state;
        beat_n  = beat;
        dbank_n = dbank;
        relu_n  = relu;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (drain_start) begin
                    state_n = DRAIN;
                    beat_n  = '0;
                    dbank_n = drain_bank;
                    relu_n  = drain_relu;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (beat == BTW'(NBEAT - 1)) begin
                        state_n = IDLE;
                        beat_n  = '0;
                        done_n  = 1'b1;
                    end else begin
                        beat_n = beat + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Drain FSM registers, the completion pulse and the sticky conflict flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            beat         <= '0;
            dbank        <= '0;
            relu         <= 1'b0;
            drain_done   <= 1'b0;
            mac_conflict <= 1'b0;
        end else begin
            state        <= state_n;
            beat         <= beat_n;
            dbank        <= dbank_n;
            relu         <= relu_n;
            drain_done   <= done_n;
            mac_conflict <= mac_conflict | (mac_valid & ~mac_accept);
        end
    end

    // Storage update. A clear from read or drain beats any write to the same
    // element. A MAC and a config write never land on the same bank together.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NBANK; b++)
                for (int p = 0; p < NPE; p++)
                    acc[b][p] <= '0;
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                for (int p = 0; p < NPE; p++) begin
                    if ((rd_clr && (cfg_rbank == BW'(b)) && (cfg_rpe == PW'(p))) ||
                        (xfer && (dbank == BW'(b)) && ((p / LANES) == int'(beat)))) begin
                        acc[b][p] <= '0;
                    end else if (mac_accept && (mac_bank == BW'(b))) begin
                        acc[b][p] <= sat_add(mac_clr ? '0 : acc[b][p],
                                             mac_prod[p*PROD_W +: PROD_W]);
                    end else if (cfg_wok && (cfg_wbank == BW'(b)) && (cfg_wpe == PW'(p))) begin
                        acc[b][p] <= cfg_wdata;
                    end
                end
            end
        end
    end

    // Config read returns the value from before this edge's update.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_rvalid <= 1'b0;
            cfg_rdata  <= '0;
        end else begin
            cfg_rvalid <= cfg_ren;
            if (cfg_ren)
                cfg_rdata <= acc[cfg_rbank][cfg_rpe];
        end
    end

    // Drain lanes are read straight from storage, with optional ReLU.
    always_comb begin
        logic [ACC_W-1:0] elem;
        out_data = '0;
        elem     = '0;
        for (int j = 0; j < LANES; j++) begin
            elem = acc[dbank][PW'(int'(beat) * LANES + j)];
            out_data[j*ACC_W +: ACC_W] = (relu && elem[ACC_W-1]) ? '0 : elem;
        end
    end

endmodule

// File: tb/tb_accreg_bank.sv
// tb_accreg_bank
// ---------------
// Bench for accreg_bank with the default parameters. A behavioural model
// holds the bank contents as plain integers. It tracks the drain as a
// bank/beat pair and is advanced once per clock from the driven inputs. It
// is compared against every DUT output after each edge. Directed scenarios
// also check literal expected values.
module tb_accreg_bank;

    localparam int NB = 8;
    localparam int NP = 16;
    localparam int AW = 32;
    localparam int PRW = 20;
    localparam int LN = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               mac_valid;
    logic [2:0]         mac_bank;
    logic               mac_clr;
    logic [NP*PRW-1:0]  mac_prod;
    logic               cfg_wen;
    logic [2:0]         cfg_wbank;
    logic [3:0]         cfg_wpe;
    logic [AW-1:0]      cfg_wdata;
    logic               cfg_ren;
    logic               cfg_rclr;
    logic [2:0]         cfg_rbank;
    logic [3:0]         cfg_rpe;
    logic               cfg_rvalid;
    logic [AW-1:0]      cfg_rdata;
    logic               drain_start;
    logic [2:0]         drain_bank;
    logic               drain_relu;
    logic               drain_busy;
    logic               out_valid;
    logic               out_ready;
    logic [LN*AW-1:0]   out_data;
    logic               out_last;
    logic               drain_done;
    logic               mac_conflict;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_acc [NB][NP];
    bit          m_busy, m_relu, m_done, m_conf, m_rvalid;
    int          m_bank, m_beat;
    logic [31:0] m_rdata;

    accreg_bank dut (
        .clk(clk), .rst(rst),
        .mac_valid(mac_valid), .mac_bank(mac_bank), .mac_clr(mac_clr), .mac_prod(mac_prod),
        .cfg_wen(cfg_wen), .cfg_wbank(cfg_wbank), .cfg_wpe(cfg_wpe), .cfg_wdata(cfg_wdata),
        .cfg_ren(cfg_ren), .cfg_rclr(cfg_rclr), .cfg_rbank(cfg_rbank), .cfg_rpe(cfg_rpe),
        .cfg_rvalid(cfg_rvalid), .cfg_rdata(cfg_rdata),
        .drain_start(drain_start), .drain_bank(drain_bank), .drain_relu(drain_relu),
        .drain_busy(drain_busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .drain_done(drain_done),
        .mac_conflict(mac_conflict)
    );

    always #5 clk = ~clk;

    function automatic int satAdd(input longint a, input longint p);
        longint s;
        s = a + p;
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        return int'(s);
    endfunction

    function automatic longint prodOf(input int i);
        logic signed [PRW-1:0] v;
        v = mac_prod[i*PRW +: PRW];
        return longint'(v);
    endfunction

    function automatic logic [LN*AW-1:0] expOut();
        logic [LN*AW-1:0] r;
        int v;
        r = '0;
        for (int j = 0; j < LN; j++) begin
            v = m_acc[m_bank][m_beat*LN + j];
            if (m_relu && v < 0) v = 0;
            r[j*AW +: AW] = v;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the currently driven inputs, then
    // let the DUT take the same edge and settle.
    task automatic applyStimulus();
        int  nxt [NB][NP];
        bit  acc_ok;
        nxt = m_acc;
        if (rst) begin
            for (int b = 0; b < NB; b++)
                for (int p = 0; p < NP; p++)
                    nxt[b][p] = 0;
            m_busy = 0; m_beat = 0; m_done = 0; m_conf = 0;
            m_rvalid = 0; m_rdata = '0; m_relu = 0; m_bank = 0;
        end else begin
            m_rvalid = cfg_ren;
            if (cfg_ren) m_rdata = m_acc[cfg_rbank][cfg_rpe];
            acc_ok = mac_valid && !(m_busy && int'(mac_bank) == m_bank);
            if (mac_valid && !acc_ok) m_conf = 1;
            if (acc_ok)
                for (int i = 0; i < NP; i++)
                    nxt[mac_bank][i] = satAdd(mac_clr ? 0 : longint'(m_acc[mac_bank][i]), prodOf(i));
            if (cfg_wen && !(acc_ok && mac_bank == cfg_wbank))
                nxt[cfg_wbank][cfg_wpe] = cfg_wdata;
            if (cfg_ren && cfg_rclr)
                nxt[cfg_rbank][cfg_rpe] = 0;
            m_done = 0;
            if (m_busy) begin
                if (out_ready) begin
                    for (int j = 0; j < LN; j++) nxt[m_bank][m_beat*LN + j] = 0;
                    if (m_beat == NP/LN - 1) begin
                        m_busy = 0; m_beat = 0; m_done = 1;
                    end else begin
                        m_beat++;
                    end
                end
            end else if (drain_start) begin
                m_busy = 1; m_bank = drain_bank; m_relu = drain_relu; m_beat = 0;
            end
        end
        m_acc = nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll();
        checkOutput("rvalid", cfg_rvalid, m_rvalid);
        checkOutput("rdata", cfg_rdata, m_rdata);
        checkOutput("busy", drain_busy, m_busy);
        checkOutput("out_valid", out_valid, m_busy);
        checkOutput("out_last", out_last, m_busy && m_beat == NP/LN - 1);
        checkOutput("drain_done", drain_done, m_done);
        checkOutput("conflict", mac_conflict, m_conf);
        if (m_busy) checkOutput("out_data", out_data, expOut());
    endtask

    task automatic cycle();
        applyStimulus();
        checkAll();
    endtask

    task automatic idleInputs();
        rst = 0; mac_valid = 0; mac_bank = 0; mac_clr = 0; mac_prod = '0;
        cfg_wen = 0; cfg_wbank = 0; cfg_wpe = 0; cfg_wdata = 0;
        cfg_ren = 0; cfg_rclr = 0; cfg_rbank = 0; cfg_rpe = 0;
        drain_start = 0; drain_bank = 0; drain_relu = 0; out_ready = 0;
    endtask

    task automatic doWrite(input int b, input int p, input logic [31:0] d);
        cfg_wen = 1; cfg_wbank = 3'(b); cfg_wpe = 4'(p); cfg_wdata = d;
        cycle();
        cfg_wen = 0;
    endtask

    task automatic doRead(input int b, input int p, input bit clr);
        cfg_ren = 1; cfg_rclr = clr; cfg_rbank = 3'(b); cfg_rpe = 4'(p);
        cycle();
        cfg_ren = 0; cfg_rclr = 0;
    endtask

    task automatic setProd(input int i, input logic [PRW-1:0] v);
        mac_prod[i*PRW +: PRW] = v;
    endtask

    initial begin
        logic [127:0] beatExp [4];
        logic [127:0] prevData;
        bit           prevStall;
        int           nb;

        idleInputs();
        m_bank = 0; m_beat = 0;

        // Reset state
        rst = 1;
        cycle();
        cycle();
        rst = 0;
        checkOutput("reset_rvalid", cfg_rvalid, 0);
        checkOutput("reset_rdata", cfg_rdata, 0);
        checkOutput("reset_busy", drain_busy, 0);
        checkOutput("reset_valid", out_valid, 0);
        checkOutput("reset_done", drain_done, 0);
        checkOutput("reset_conflict", mac_conflict, 0);

        // Positive saturation
        doWrite(2, 5, 32'h7FFF_FFF0);
        mac_valid = 1; mac_bank = 2; mac_prod = '0; setProd(5, 20'h7FFFF);
        cycle();
        mac_valid = 0;
        doRead(2, 5, 0);
        checkOutput("pos_sat", cfg_rdata, 32'h7FFF_FFFF);

        // Negative saturation
        doWrite(2, 5, 32'h8000_0010);
        mac_valid = 1; mac_bank = 2; mac_prod = '0; setProd(5, 20'hFFF00);
        cycle();
        mac_valid = 0;
        doRead(2, 5, 0);
        checkOutput("neg_sat", cfg_rdata, 32'h8000_0000);

        // Overwrite on first MAC, then accumulate
        for (int p = 0; p < NP; p++) doWrite(1, p, 32'd100);
        mac_valid = 1; mac_bank = 1; mac_clr = 1;
        for (int i = 0; i < NP; i++) setProd(i, 20'hFFFFD);
        cycle();
        mac_valid = 0; mac_clr = 0;
        doRead(1, 0, 0);
        checkOutput("clr_pe0", cfg_rdata, 32'hFFFF_FFFD);
        doRead(1, 15, 0);
        checkOutput("clr_pe15", cfg_rdata, 32'hFFFF_FFFD);
        mac_valid = 1;
        cycle();
        mac_valid = 0;
        doRead(1, 7, 0);
        checkOutput("acc_pe7", cfg_rdata, 32'hFFFF_FFFA);

        // Drain with ReLU and backpressure
        for (int p = 0; p < NP; p++) doWrite(3, p, 32'(p - 8));
        beatExp[0] = '0;
        beatExp[1] = '0;
        beatExp[2] = {32'd3, 32'd2, 32'd1, 32'd0};
        beatExp[3] = {32'd7, 32'd6, 32'd5, 32'd4};
        drain_start = 1; drain_bank = 3; drain_relu = 1;
        cycle();
        drain_start = 0;
        checkOutput("drain_valid_rise", out_valid, 1);
        nb = 0;
        prevStall = 0;
        prevData = '0;
        for (int k = 0; k < 40 && nb < 4; k++) begin
            out_ready = (k % 3 == 0);
            if (prevStall) checkOutput("stall_hold", out_data, prevData);
            if (out_valid && out_ready) begin
                checkOutput($sformatf("beat%0d", nb), out_data, beatExp[nb]);
                checkOutput($sformatf("last%0d", nb), out_last, nb == 3);
                nb++;
            end
            prevStall = out_valid && !out_ready;
            prevData = out_data;
            cycle();
        end
        checkOutput("drain_beats", nb, 4);
        checkOutput("done_pulse", drain_done, 1);
        out_ready = 0;
        cycle();
        checkOutput("done_once", drain_done, 0);
        for (int p = 0; p < NP; p++) begin
            doRead(3, p, 0);
            checkOutput("drained_zero", cfg_rdata, 0);
        end

        // Conflict: MAC to the draining bank is dropped, another bank is fine
        drain_start = 1; drain_bank = 0; drain_relu = 0;
        cycle();
        drain_start = 0;
        mac_valid = 1; mac_bank = 0;
        for (int i = 0; i < NP; i++) setProd(i, 20'd9);
        cycle();
        checkOutput("conflict_set", mac_conflict, 1);
        mac_bank = 4;
        for (int i = 0; i < NP; i++) setProd(i, 20'd7);
        cycle();
        mac_valid = 0;
        out_ready = 1;
        for (int k = 0; k < 4; k++) cycle();
        out_ready = 0;
        cycle();
        doRead(4, 2, 0);
        checkOutput("other_bank_mac", cfg_rdata, 32'd7);
        doRead(0, 2, 0);
        checkOutput("dropped_mac", cfg_rdata, 0);

        // Clear-on-read against a same-cycle MAC, colliding config write dropped
        doWrite(7, 15, 32'd42);
        cfg_ren = 1; cfg_rclr = 1; cfg_rbank = 7; cfg_rpe = 15;
        mac_valid = 1; mac_bank = 7; mac_prod = '0; setProd(15, 20'd5);
        cfg_wen = 1; cfg_wbank = 7; cfg_wpe = 3; cfg_wdata = 32'd999;
        cycle();
        idleInputs();
        checkOutput("rclr_data", cfg_rdata, 32'd42);
        doRead(7, 15, 0);
        checkOutput("rclr_zero", cfg_rdata, 0);
        doRead(7, 3, 0);
        checkOutput("wen_dropped", cfg_rdata, 0);

        // Randomized traffic checked against the model every cycle
        for (int k = 0; k < 400; k++) begin
            mac_valid   = ($urandom % 2) == 0;
            mac_bank    = 3'($urandom);
            mac_clr     = ($urandom % 8) == 0;
            for (int i = 0; i < NP; i++)
                setProd(i, ($urandom % 4 == 0) ? (($urandom % 2) ? 20'h7FFFF : 20'h80000)
                                               : 20'($urandom));
            cfg_wen     = ($urandom % 4) == 0;
            cfg_wbank   = 3'($urandom);
            cfg_wpe     = 4'($urandom);
            cfg_wdata   = ($urandom % 2) ? $urandom : ($urandom % 2 ? 32'h7FFF_FF00 : 32'h8000_0100);
            cfg_ren     = ($urandom % 3) == 0;
            cfg_rclr    = ($urandom % 4) == 0;
            cfg_rbank   = 3'($urandom);
            cfg_rpe     = 4'($urandom);
            drain_start = ($urandom % 8) == 0;
            drain_bank  = 3'($urandom);
            drain_relu  = 1'($urandom);
            out_ready   = 1'($urandom);
            cycle();
        end
        idleInputs();

        // Reset in the middle of a drain
        for (int p = 0; p < 8; p++) doWrite(5, p, 32'd11);
        drain_start = 1; drain_bank = 5; drain_relu = 0; out_ready = 1;
        cycle();
        drain_start = 0;
        cycle();
        rst = 1;
        cycle();
        rst = 0; out_ready = 0;
        checkOutput("rst_mid_valid", out_valid, 0);
        checkOutput("rst_mid_busy", drain_busy, 0);
        cycle();
        checkOutput("rst_mid_nodone", drain_done, 0);
        for (int b = 0; b < NB; b++) begin
            for (int p = 0; p < NP; p += 3) begin
                doRead(b, p, 0);
                checkOutput("rst_mid_zero", cfg_rdata, 0);
            end
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
